// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop stage: buffers set/clear/toggle/hold
// commands, issues each as a one-cycle {j,k} pulse and checks the fed-back Q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  output logic                       j,
  output logic                       k,
  input  logic                       q_fb,
  output logic                       exp_q,
  output logic                       mismatch,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, WAIT} state_t;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_reg;
  logic [3:0]    wait_cnt;
  state_t        state;
  logic          push;
  logic          pop;
  logic          pop_slot;

  assign level     = level_reg;
  assign cmd_ready = (level_reg < LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  // A pop is allowed in every state that may be followed directly by ISSUE.
  always_comb begin
    pop_slot = 1'b0;
    case (state)
      IDLE:    pop_slot = 1'b1;
      CHECK:   pop_slot = (GAP == 0);
      WAIT:    pop_slot = (wait_cnt == 4'd0);
      default: pop_slot = 1'b0;
    endcase
    pop = pop_slot && (level_reg != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      j        <= 1'b0;
      k        <= 1'b0;
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      j <= 1'b0;
      k <= 1'b0;

      // A fresh mismatch takes priority over a simultaneous clear.
      if (state == CHECK && q_fb != exp_q) begin
        mismatch <= 1'b1;
      end else if (clr_err) begin
        mismatch <= 1'b0;
      end

      case (state)
        ISSUE: begin
          case ({j, k})
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= ~exp_q;
            default: exp_q <= exp_q;
          endcase
          state <= CHECK;
        end
        CHECK: begin
          if (GAP > 0) begin
            wait_cnt <= GAP_M1;
            state    <= WAIT;
          end else if (pop) begin
            {j, k} <= mem[rd_ptr];
            state  <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (pop) begin
            {j, k} <= mem[rd_ptr];
            state  <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (pop) begin
            {j, k} <= mem[rd_ptr];
            state  <= ISSUE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: three instances (GAP 0, 3, 15) each driving a
// behavioural JK stage; directed and random command streams checked against rules.
module tb_jk_cmd_sequencer;

  localparam int N  = 3;
  localparam int HN = 4096;
  localparam int PL = 64;
  localparam int GAPS [N] = '{0, 3, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_valid [N];
  logic       cmd_ready [N];
  logic [1:0] cmd_op    [N];
  logic       j_s       [N];
  logic       k_s       [N];
  logic       q_fb      [N];
  logic       exp_q     [N];
  logic       mism      [N];
  logic       clr_err   [N];
  logic [2:0] lvl       [N];
  logic       q_m       [N];
  logic       force0    [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      jk_cmd_sequencer #(.DEPTH(4), .GAP(GAPS[gi])) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]),
        .cmd_op(cmd_op[gi]), .j(j_s[gi]), .k(k_s[gi]), .q_fb(q_fb[gi]), .exp_q(exp_q[gi]),
        .mismatch(mism[gi]), .clr_err(clr_err[gi]), .level(lvl[gi])
      );
    end
  endgenerate

  // Behavioural JK stage, held in reset by the same system reset.
  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) q_m[i] <= 1'b0;
      else case ({j_s[i], k_s[i]})
        2'b01:   q_m[i] <= 1'b0;
        2'b10:   q_m[i] <= 1'b1;
        2'b11:   q_m[i] <= ~q_m[i];
        default: q_m[i] <= q_m[i];
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) q_fb[i] = force0[i] ? 1'b0 : q_m[i];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle history and pulse log, sampled at the falling edge.
  logic [1:0] jk_hist  [N][HN];
  logic       exp_hist [N][HN];
  logic       mm_hist  [N][HN];
  int         pcyc     [N][PL];
  logic [1:0] pop_l    [N][PL];
  int pcnt[N]      = '{default: 0};
  int maxlvl[N]    = '{default: 0};
  int rdy_bad[N]   = '{default: 0};
  int full_seen[N] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cyc < HN) begin
        jk_hist[i][cyc]  = {j_s[i], k_s[i]};
        exp_hist[i][cyc] = exp_q[i];
        mm_hist[i][cyc]  = mism[i];
      end
      if ({j_s[i], k_s[i]} != 2'b00 && pcnt[i] < PL) begin
        pcyc[i][pcnt[i]]  = cyc;
        pop_l[i][pcnt[i]] = {j_s[i], k_s[i]};
        pcnt[i]++;
      end
      if (int'(lvl[i]) > maxlvl[i]) maxlvl[i] = int'(lvl[i]);
      if (cmd_ready[i] !== (lvl[i] < 3'd4)) rdy_bad[i]++;
      if (lvl[i] == 3'd4 && !cmd_ready[i]) full_seen[i]++;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic apply(input logic q, input logic [1:0] op);
    case (op)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents op until accepted; returns at the following falling edge with the accept-edge index.
  task automatic push(input int i, input logic [1:0] op, output int acc);
    logic was;
    bit   done;
    done = 0;
    acc  = 0;
    cmd_valid[i] = 1'b1;
    cmd_op[i]    = op;
    for (int b = 0; b < 300 && !done; b++) begin
      was = cmd_ready[i];
      @(posedge clk);
      step();
      if (was) begin
        acc  = cyc;
        done = 1;
      end
    end
    if (!done) chk($sformatf("push_accept_%0d", i), 0, 1);
  endtask

  task automatic wait_pulses(input int i, input int n, input int budget);
    for (int b = 0; b < budget && pcnt[i] < n; b++) step();
    chk($sformatf("pulse_arrival_%0d", i), 32'(pcnt[i] >= n), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          acc, n0, base, pc, nz;
  logic        q0, q1, found;
  logic [1:0]  seq_ops [4] = '{2'b10, 2'b11, 2'b11, 2'b01};
  logic [1:0]  bp_ops  [8] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
  logic [1:0]  rops    [12];
  logic [1:0]  rexp    [12];

  initial begin
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      cmd_valid[i] = 1'b0; cmd_op[i] = 2'b00; clr_err[i] = 1'b0; force0[i] = 1'b0;
    end
    step(); step();
    chk("rst_j", 32'(j_s[0]), 0);
    chk("rst_k", 32'(k_s[0]), 0);
    chk("rst_exp_q", 32'(exp_q[0]), 0);
    chk("rst_mismatch", 32'(mism[0]), 0);
    chk("rst_level", 32'(lvl[0]), 0);
    chk("rst_ready", 32'(cmd_ready[0]), 1);
    reset = 1'b1;
    step();

    // Back-to-back sequence, GAP=0: push in cycle c gives a pulse in cycle c+2.
    q0 = 1'b0;
    base = pcnt[0];
    for (int n = 0; n < 4; n++) begin
      push(0, seq_ops[n], acc);
      if (n == 0) n0 = acc;
    end
    cmd_valid[0] = 1'b0;
    wait_pulses(0, base + 4, 40);
    for (int n = 0; n < 4; n++) begin
      q0 = apply(q0, seq_ops[n]);
      chk($sformatf("seq_op_%0d", n), 32'(pop_l[0][base+n]), 32'(seq_ops[n]));
      chk($sformatf("seq_cyc_%0d", n), 32'(pcyc[0][base+n]), 32'(n0 + 1 + 2 * n));
      chk($sformatf("seq_exp_%0d", n), 32'(exp_hist[0][pcyc[0][base+n]+1]), 32'(q0));
    end
    chk("seq_mismatch", 32'(mism[0]), 0);

    // Hold command: occupies a slot, leaves exp_q alone.
    base = pcnt[0];
    push(0, 2'b10, n0);
    push(0, 2'b00, acc);
    push(0, 2'b11, acc);
    cmd_valid[0] = 1'b0;
    wait_pulses(0, base + 2, 40);
    q0 = apply(q0, 2'b10);
    chk("hold_first_cyc", 32'(pcyc[0][base]), 32'(n0 + 1));
    chk("hold_exp_before", 32'(exp_hist[0][n0+2]), 32'(q0));
    chk("hold_issue_jk", 32'(jk_hist[0][n0+3]), 0);
    q0 = apply(q0, 2'b00);
    chk("hold_exp_after", 32'(exp_hist[0][n0+4]), 32'(q0));
    chk("hold_next_cyc", 32'(pcyc[0][base+1]), 32'(n0 + 5));
    chk("hold_next_op", 32'(pop_l[0][base+1]), 32'(2'b11));
    q0 = apply(q0, 2'b11);
    chk("hold_next_exp", 32'(exp_hist[0][n0+6]), 32'(q0));
    chk("hold_mismatch", 32'(mism[0]), 0);

    // Spacing, GAP=3: four toggles, leading edges 5 cycles apart.
    q1 = 1'b0;
    base = pcnt[1];
    for (int n = 0; n < 4; n++) begin
      push(1, 2'b11, acc);
      if (n == 0) n0 = acc;
    end
    cmd_valid[1] = 1'b0;
    wait_pulses(1, base + 4, 60);
    for (int n = 0; n < 4; n++) begin
      q1 = apply(q1, 2'b11);
      chk($sformatf("gap3_cyc_%0d", n), 32'(pcyc[1][base+n]), 32'(n0 + 1 + 5 * n));
      chk($sformatf("gap3_exp_%0d", n), 32'(exp_hist[1][pcyc[1][base+n]+1]), 32'(q1));
    end
    chk("gap3_mismatch", 32'(mism[1]), 0);

    // Backpressure, GAP=15: eight ops through a four-entry FIFO.
    base = pcnt[2];
    for (int n = 0; n < 8; n++) begin
      push(2, bp_ops[n], acc);
      if (n == 0) n0 = acc;
    end
    cmd_valid[2] = 1'b0;
    wait_pulses(2, base + 8, 300);
    repeat (40) step();
    chk("bp_issue_count", 32'(pcnt[2] - base), 8);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("bp_op_%0d", n), 32'(pop_l[2][base+n]), 32'(bp_ops[n]));
      chk($sformatf("bp_cyc_%0d", n), 32'(pcyc[2][base+n]), 32'(n0 + 1 + 17 * n));
    end
    chk("bp_max_level", 32'(maxlvl[2]), 4);
    chk("bp_ready_rule", 32'(rdy_bad[2]), 0);
    chk("bp_full_seen", 32'(full_seen[2] > 0), 1);
    chk("bp_mismatch", 32'(mism[2]), 0);

    // Error path: Q tied low against a set.
    force0[0] = 1'b1;
    push(0, 2'b10, n0);
    cmd_valid[0] = 1'b0;
    q0 = apply(q0, 2'b10);
    step(); step(); step();
    chk("err_before_check_end", 32'(mm_hist[0][n0+2]), 0);
    chk("err_at_check_end", 32'(mm_hist[0][n0+3]), 1);
    repeat (5) step();
    chk("err_sticky", 32'(mism[0]), 1);
    clr_err[0] = 1'b1; step(); clr_err[0] = 1'b0;
    chk("err_cleared", 32'(mism[0]), 0);
    push(0, 2'b10, n0);
    cmd_valid[0] = 1'b0;
    q0 = apply(q0, 2'b10);
    step(); step();
    clr_err[0] = 1'b1; step(); clr_err[0] = 1'b0;
    chk("err_set_wins_pre", 32'(mm_hist[0][n0+2]), 0);
    chk("err_set_wins", 32'(mism[0]), 1);
    clr_err[0] = 1'b1; step(); clr_err[0] = 1'b0;
    chk("err_recleared", 32'(mism[0]), 0);
    force0[0] = 1'b0;

    // Random command stream with random idle gaps, GAP=0.
    base = pcnt[0];
    nz = 0;
    for (int n = 0; n < 12; n++) begin
      rops[n] = 2'($urandom_range(0, 3));
      q0 = apply(q0, rops[n]);
      if (rops[n] != 2'b00) begin
        rexp[nz] = rops[n];
        nz++;
      end
      push(0, rops[n], acc);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid[0] = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    cmd_valid[0] = 1'b0;
    wait_pulses(0, base + nz, 80);
    repeat (6) step();
    chk("rnd_pulse_count", 32'(pcnt[0] - base), 32'(nz));
    for (int n = 0; n < nz; n++) begin
      chk($sformatf("rnd_op_%0d", n), 32'(pop_l[0][base+n]), 32'(rexp[n]));
      if (n > 0) chk($sformatf("rnd_spacing_%0d", n), 32'(pcyc[0][base+n] - pcyc[0][base+n-1] >= 2), 1);
    end
    chk("rnd_exp_q", 32'(exp_q[0]), 32'(q0));
    chk("rnd_mismatch", 32'(mism[0]), 0);
    chk("rnd_level", 32'(lvl[0]), 0);

    // Asynchronous reset mid-ISSUE with three commands queued.
    force0[0] = 1'b1;
    push(0, 2'b10, acc);
    cmd_valid[0] = 1'b0;
    repeat (4) step();
    chk("pre_rst_mismatch", 32'(mism[0]), 1);
    for (int n = 0; n < 5; n++) push(2, 2'b10, acc);
    cmd_valid[2] = 1'b0;
    found = 1'b0;
    for (int b = 0; b < 60 && !found; b++) begin
      if ({j_s[2], k_s[2]} != 2'b00 && lvl[2] == 3'd3) found = 1'b1;
      else step();
    end
    chk("rst_issue_found", 32'(found), 1);
    reset = 1'b0;
    #1;
    chk("arst_j", 32'(j_s[2]), 0);
    chk("arst_k", 32'(k_s[2]), 0);
    chk("arst_exp_q", 32'(exp_q[2]), 0);
    chk("arst_level", 32'(lvl[2]), 0);
    chk("arst_ready", 32'(cmd_ready[2]), 1);
    chk("arst_mismatch", 32'(mism[0]), 0);
    step();
    reset = 1'b1;
    force0[0] = 1'b0;
    pc = pcnt[2];
    repeat (30) step();
    chk("post_rst_no_pulse", 32'(pcnt[2] - pc), 0);
    chk("post_rst_level", 32'(lvl[2]), 0);
    chk("post_rst_mismatch", 32'(mism[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
